seven_seg_scanner: RTL and testbench

//  Time-multiplexes a packed hex value onto NUM_DIGITS common-anode 7-seg digits.

---
 rtl/seven_seg_pkg.sv | 30 +++
 rtl/refresh_prescaler.sv | 21 ++
 rtl/seven_seg_scanner.sv | 121 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and the leading-zero blank-mask helper for the 7-seg scanner.
package seven_seg_pkg;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int NIB_W          = 4;
  // Widest display the helper function supports; callers zero-extend into it.
  localparam int MAX_DIGITS     = 16;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Bit i set means digit i is a leading zero and must stay dark.
  // Digit 0 is never blanked, so a value of zero still shows a single "0".
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [NIB_W*MAX_DIGITS-1:0] shadow,
    input int                          num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = MAX_DIGITS-1; i >= 1; i--) begin
      if (i < num_digits) begin
        all_zero = all_zero & (shadow[i*NIB_W +: NIB_W] == '0);
        mask[i]  = all_zero;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running slot counter: counts 0..DIV-1 and flags the last cycle of each slot.
module refresh_prescaler #(
  parameter  int DIV = 50000,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] count,
  output logic          tick
);

  assign tick = (count == CW'(DIV-1));

  // Slot counter, wraps to zero on the terminal count.
  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + CW'(1);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes a packed hex value onto common-anode 7-seg digits with
// per-digit enables, decimal points, optional leading-zero blanking and a
// dark guard window at the start of every slot to avoid ghosting.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 16,
  parameter int LZ_BLANK    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  output logic [NIB_W-1:0]            hex_digit,
  output logic [NUM_DIGITS-1:0]       anode_n,
  output logic                        dp_n,
  output logic                        frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]               count;
  logic                        tick;
  logic [IW-1:0]               idx;
  logic                        wrap;
  logic                        load_pending;
  logic [NIB_W*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]       en_sh;
  logic [NUM_DIGITS-1:0]       dp_sh;
  logic [NIB_W*MAX_DIGITS-1:0] shadow_ext;
  logic [MAX_DIGITS-1:0]       mask_full;
  logic [NUM_DIGITS-1:0]       blank;
  logic [NUM_DIGITS-1:0]       lit;
  logic [NIB_W-1:0]            nib;
  logic                        active;
  logic                        unused_mask;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .tick  (tick)
  );

  assign wrap = tick && (idx == IW'(NUM_DIGITS-1));

  // Digit index advances once per slot and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (reset)     idx <= '0;
    else if (wrap) idx <= '0;
    else if (tick) idx <= idx + IW'(1);
  end

  // Remembers that the first edge after reset must capture the inputs.
  always_ff @(posedge clk) begin
    if (reset) load_pending <= 1'b1;
    else       load_pending <= 1'b0;
  end

  // Frame-coherent copy of value/enables/dps, refreshed only at frame wrap
  // (and once on reset exit) so a mid-frame update never tears the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      en_sh  <= '0;
      dp_sh  <= '0;
    end else if (load_pending || wrap) begin
      shadow <= value;
      en_sh  <= digit_en;
      dp_sh  <= dp_in;
    end
  end

  // Single-cycle pulse coincident with the shadow reload at wrap.
  always_ff @(posedge clk) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= wrap;
  end

  // Zero-extend the shadow so the package helper can handle any width.
  always_comb begin
    shadow_ext                       = '0;
    shadow_ext[NIB_W*NUM_DIGITS-1:0] = shadow;
  end

  assign mask_full   = lz_mask(shadow_ext, NUM_DIGITS);
  assign blank       = (LZ_BLANK != 0) ? mask_full[NUM_DIGITS-1:0] : '0;
  assign unused_mask = ^mask_full;

  // Nibble of the current slot; shown even while the anode is dark.
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) nib = shadow[i*NIB_W +: NIB_W];
    end
  end

  assign active = (int'(count) >= GUARD_CYC);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign lit[i] = (idx == IW'(i)) && active && en_sh[i] && !blank[i];
  end

  // Registered outputs; held at idle values for the edge that loads the shadow.
  always_ff @(posedge clk) begin
    if (reset || load_pending) begin
      anode_n   <= ANODE_OFF[NUM_DIGITS-1:0];
      hex_digit <= '0;
      dp_n      <= 1'b1;
    end else begin
      anode_n   <= ~lit;
      hex_digit <= nib;
      dp_n      <= ~(|(lit & dp_sh));
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench: a cycle model pushes expected outputs at each rising
// edge; scenario tasks pop and compare on the falling edge, plus targeted checks.
module tb_seven_seg_scanner;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
    logic       fd;
    logic [3:0] an_lz;
    logic       dp_lz;
    logic [3:0] hex_lz;
    logic       fd_lz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  hex_digit, anode_n, hex_lz, anode_lz;
  logic        dp_n, frame_done, dp_lz, fd_lz;
  exp_t        obs;
  exp_t        expq[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYC(1), .LZ_BLANK(0)) dut (
    .clk(clk), .reset(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .hex_digit(hex_digit), .anode_n(anode_n), .dp_n(dp_n), .frame_done(frame_done));

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYC(1), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .reset(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
    .hex_digit(hex_lz), .anode_n(anode_lz), .dp_n(dp_lz), .frame_done(fd_lz));

  assign obs = {anode_n, hex_digit, dp_n, frame_done, anode_lz, dp_lz, hex_lz, fd_lz};

  // Reference model. k counts non-reset edges since release; output after edge k
  // shows slot phase c=k-1 (edge 1 is forced idle). Inputs captured at k=1 and k%16==0.
  int          mk;
  logic [15:0] m_val;
  logic [3:0]  m_en, m_dp;
  always @(posedge clk) begin : model
    int   k, c, s, ph;
    logic lit, lit_lz;
    exp_t e;
    e = {4'hF, 4'h0, 1'b1, 1'b0, 4'hF, 1'b1, 4'h0, 1'b0};
    k = rst ? 0 : mk + 1;
    if (k >= 2) begin
      c = k - 1; s = (c / 4) % 4; ph = c % 4;
      lit    = (ph >= 1) && m_en[s];
      lit_lz = lit && !(s > 0 && (m_val >> (4 * s)) == 16'h0);
      e.hex    = m_val[4*s +: 4];
      e.hex_lz = m_val[4*s +: 4];
      if (lit)    begin e.an    = ~(4'b0001 << s); e.dp    = ~m_dp[s]; end
      if (lit_lz) begin e.an_lz = ~(4'b0001 << s); e.dp_lz = ~m_dp[s]; end
    end
    e.fd    = (k > 0) && (k % 16 == 0);
    e.fd_lz = e.fd;
    expq.push_back(e);
    mk <= k;
    if (k == 0) begin
      m_val <= '0; m_en <= '0; m_dp <= '0;
    end else if (k == 1 || k % 16 == 0) begin
      m_val <= value; m_en <= digit_en; m_dp <= dp_in;
    end
  end

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    expq.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    value = 16'hFFFF; digit_en = 4'hF; dp_in = 4'hF; rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) rst = 1'b0;  // released after three reset edges
      @(negedge clk);
      tests++;
      if (expq.size() == 0) begin fails++; $display("FAIL reset_sb empty queue"); end
      else begin
        e = expq.pop_front();
        if (obs !== e) begin fails++; $display("FAIL reset_sb obs=%h exp=%h", obs, e); end
      end
      if (k <= 3) begin
        tests++;
        if ({anode_n, hex_digit, dp_n, frame_done} !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
          fails++; $display("FAIL reset_idle k=%0d an=%b hex=%h dp=%b fd=%b exp 1111/0/1/0",
                            k, anode_n, hex_digit, dp_n, frame_done);
        end
      end
      if (k == 4) begin
        tests++;
        if ({anode_n, hex_digit, dp_n} !== {4'hE, 4'hF, 1'b0}) begin
          fails++; $display("FAIL reset_first_lit an=%b hex=%h dp=%b exp 1110/F/0", anode_n, hex_digit, dp_n);
        end
      end
    end
  endtask

  task automatic test_scan();
    exp_t       e;
    logic [3:0] eh[4] = '{4'hF, 4'h2, 4'hA, 4'h1};
    logic [3:0] ea[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    value = 16'h1A2F; digit_en = 4'hF; dp_in = 4'h0;
    apply_reset(2);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tests++;
      if (expq.size() == 0) begin fails++; $display("FAIL scan_sb empty queue"); end
      else begin
        e = expq.pop_front();
        if (obs !== e) begin fails++; $display("FAIL scan_sb k=%0d obs=%h exp=%h", k, obs, e); end
      end
      for (int s = 0; s < 4; s++) begin
        if (k == 4*s + 1 && s > 0) begin
          tests++;
          if (anode_n !== 4'hF || hex_digit !== eh[s]) begin
            fails++; $display("FAIL scan_guard s=%0d an=%b hex=%h exp 1111/%h", s, anode_n, hex_digit, eh[s]);
          end
        end
        if (k == 4*s + 3) begin
          tests++;
          if (anode_n !== ea[s] || hex_digit !== eh[s]) begin
            fails++; $display("FAIL scan_slot s=%0d an=%b hex=%h exp %b/%h", s, anode_n, hex_digit, ea[s], eh[s]);
          end
        end
      end
    end
  endtask

  task automatic test_shadow();
    exp_t       e;
    int         pulses = 0;
    logic [3:0] nxt[4] = '{4'h8, 4'h7, 4'h6, 4'h5};
    value = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;
    apply_reset(1);
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      tests++;
      if (expq.size() == 0) begin fails++; $display("FAIL shadow_sb empty queue"); end
      else begin
        e = expq.pop_front();
        if (obs !== e) begin fails++; $display("FAIL shadow_sb k=%0d obs=%h exp=%h", k, obs, e); end
      end
      if (k == 6) value = 16'h5678;  // changed while slot 1 is on display
      if (frame_done) pulses++;
      tests++;
      if (frame_done !== (k % 16 == 0)) begin
        fails++; $display("FAIL shadow_fd k=%0d fd=%b exp %b", k, frame_done, k % 16 == 0);
      end
      // Old frame keeps nibbles 2,1 on slots 2,3; the next frame carries 8,7,6,5.
      if (k == 11 && hex_digit !== 4'h2) begin
        fails++; $display("FAIL shadow_tear2 hex=%h exp 2", hex_digit);
      end
      if (k == 15 && hex_digit !== 4'h1) begin
        fails++; $display("FAIL shadow_tear3 hex=%h exp 1", hex_digit);
      end
      if (k == 11 || k == 15) tests++;
      for (int s = 0; s < 4; s++) begin
        if (k == 16 + 4*s + 3) begin
          tests++;
          if (hex_digit !== nxt[s]) begin
            fails++; $display("FAIL shadow_next s=%0d hex=%h exp %h", s, hex_digit, nxt[s]);
          end
        end
      end
    end
    tests++;
    if (pulses != 3) begin fails++; $display("FAIL shadow_pulses got=%0d exp 3", pulses); end
  endtask

  task automatic test_lz();
    exp_t e;
    value = 16'h0042; digit_en = 4'hF; dp_in = 4'h0;
    apply_reset(1);
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      tests++;
      if (expq.size() == 0) begin fails++; $display("FAIL lz_sb empty queue"); end
      else begin
        e = expq.pop_front();
        if (obs !== e) begin fails++; $display("FAIL lz_sb k=%0d obs=%h exp=%h", k, obs, e); end
      end
      if (k == 8) value = 16'h0000;
      if (k <= 16) begin
        tests++;
        if (anode_lz[3:2] !== 2'b11) begin fails++; $display("FAIL lz_dark an=%b exp 11xx", anode_lz); end
      end else begin
        tests++;
        if (anode_lz !== 4'hF && anode_lz !== 4'hE) begin
          fails++; $display("FAIL lz_zero_only an=%b exp 1111 or 1110", anode_lz);
        end
      end
      if (k == 3 || k == 7 || k == 19 || k == 23) begin
        tests++;
        if ((k == 3  && {anode_lz, hex_lz} !== {4'hE, 4'h2}) ||
            (k == 7  && {anode_lz, hex_lz} !== {4'hD, 4'h4}) ||
            (k == 19 && {anode_lz, hex_lz} !== {4'hE, 4'h0}) ||
            (k == 23 && anode_lz !== 4'hF)) begin
          fails++; $display("FAIL lz_digit k=%0d an=%b hex=%h", k, anode_lz, hex_lz);
        end
      end
    end
  endtask

  task automatic test_enable_dp();
    exp_t e;
    int   dp_cnt = 0;
    value = 16'h1A2F; digit_en = 4'b0101; dp_in = 4'b0110;
    apply_reset(1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      tests++;
      if (expq.size() == 0) begin fails++; $display("FAIL endp_sb empty queue"); end
      else begin
        e = expq.pop_front();
        if (obs !== e) begin fails++; $display("FAIL endp_sb k=%0d obs=%h exp=%h", k, obs, e); end
      end
      tests++;
      if (anode_n[1] !== 1'b1 || anode_n[3] !== 1'b1 || (dp_n === 1'b0 && anode_n !== 4'hB)) begin
        fails++; $display("FAIL endp_mask k=%0d an=%b dp=%b", k, anode_n, dp_n);
      end
      if (dp_n === 1'b0) dp_cnt++;
    end
    tests++;
    if (dp_cnt != 6) begin fails++; $display("FAIL endp_dpcount got=%0d exp 6", dp_cnt); end
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    value = 16'h1A2F; digit_en = 4'hF; dp_in = 4'h0;
    apply_reset(1);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      tests++;
      if (expq.size() == 0) begin fails++; $display("FAIL mrst_sb empty queue"); end
      else begin
        e = expq.pop_front();
        if (obs !== e) begin fails++; $display("FAIL mrst_sb k=%0d obs=%h exp=%h", k, obs, e); end
      end
      if (k == 10) rst = 1'b1;  // slot 2 on display
      if (k == 11) begin
        rst = 1'b0;
        tests++;
        if ({anode_n, hex_digit, frame_done} !== {4'hF, 4'h0, 1'b0}) begin
          fails++; $display("FAIL mrst_idle an=%b hex=%h fd=%b exp 1111/0/0", anode_n, hex_digit, frame_done);
        end
      end
      if (k > 11) begin
        tests++;
        if (frame_done !== (k - 11 == 16)) begin
          fails++; $display("FAIL mrst_fd j=%0d fd=%b exp %b", k - 11, frame_done, k - 11 == 16);
        end
      end
      if (k == 14) begin
        tests++;
        if ({anode_n, hex_digit} !== {4'hE, 4'hF}) begin
          fails++; $display("FAIL mrst_restart an=%b hex=%h exp 1110/F", anode_n, hex_digit);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_shadow();
    test_lz();
    test_enable_dp();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
